// File: rtl/m3_key_pkg.sv
// Shared key indices, repeat-FSM state type and counter sizing helper
// for the motor-command key conditioner.
package m3_key_pkg;

  localparam int KEY_START      = 0;
  localparam int KEY_FORCE_STOP = 1;
  localparam int KEY_INV_ROTATE = 2;
  localparam int KEY_SPD_DEC    = 3;
  localparam int KEY_SPD_INC    = 4;
  localparam int KEY_PWR_INC    = 5;
  localparam int KEY_PWR_DEC    = 6;

  localparam int NUM_KEYS = 7;
  localparam int NUM_REP  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } rep_state_t;

  // Counter width able to hold 0..maxVal-1, never narrower than one bit.
  function automatic int cntWidth(input int maxVal);
    return (maxVal > 1) ? $clog2(maxVal) : 1;
  endfunction

endpackage

// File: rtl/m3_key_debounce_bit.sv
// One key lane: 2-FF synchronizer, sample-tick debounce counter and
// rising-edge (press) detect on the debounced state.
module m3_key_debounce_bit
  import m3_key_pkg::*;
#(
  parameter int DEB_CNT        = 3,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic clkI,
  input  logic rstI,
  input  logic keyRawI,
  input  logic sampleTick,
  output logic stateO,
  output logic pressO
);

  localparam int DW = cntWidth(DEB_CNT);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);

  logic          sync1Reg;
  logic          sync2Reg;
  logic          stateReg;
  logic          statePrevReg;
  logic [DW-1:0] debCntReg;
  logic          sample;

  assign sample = KEY_ACTIVE_LOW ? ~sync2Reg : sync2Reg;

  always_ff @(posedge clkI) begin
    if (rstI) begin
      sync1Reg     <= 1'b0;
      sync2Reg     <= 1'b0;
      stateReg     <= 1'b0;
      statePrevReg <= 1'b0;
      debCntReg    <= '0;
    end else begin
      sync1Reg     <= keyRawI;
      sync2Reg     <= sync1Reg;
      statePrevReg <= stateReg;
      if (sampleTick) begin
        if (sample == stateReg) begin
          debCntReg <= '0;
        end else if (debCntReg >= DEB_LAST) begin
          // DEB_CNT consecutive differing samples seen: accept the new level
          stateReg  <= ~stateReg;
          debCntReg <= '0;
        end else begin
          debCntReg <= debCntReg + 1'b1;
        end
      end
    end
  end

  assign stateO = stateReg;
  assign pressO = stateReg & ~statePrevReg;

endmodule

// File: rtl/m3_key_cmd_conditioner.sv
// Key front end: prescaler, 7 debounced key lanes, INC/DEC auto-repeat FSMs,
// conflict/forceStop gating and registered command outputs.
module m3_key_cmd_conditioner
  import m3_key_pkg::*;
#(
  parameter int CLK_PER_SAMPLE = 10000,
  parameter int DEB_CNT        = 3,
  parameter int REP_DELAY      = 50,
  parameter int REP_RATE       = 10,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic       clkI,
  input  logic       rstI,
  input  logic [6:0] keyRawI,
  output logic       m3startO,
  output logic       m3forceStopO,
  output logic       m3invRotateO,
  output logic       m3speedDECo,
  output logic       m3speedINCo,
  output logic       m3powerINCo,
  output logic       m3powerDECo,
  output logic [6:0] keyStateO
);

  localparam int PW = cntWidth(CLK_PER_SAMPLE);
  localparam int RW = cntWidth((REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE);
  localparam logic [PW-1:0] PRE_LAST   = PW'(CLK_PER_SAMPLE - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REP_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REP_RATE - 1);

  logic [PW-1:0]         preCntReg;
  logic                  sampleTick;
  logic [NUM_KEYS-1:0]   keyState;
  logic [NUM_KEYS-1:0]   keyPress;
  logic [NUM_REP-1:0]    repPulse;
  logic [NUM_REP-1:0]    cmdReg;
  logic                  forceStop;
  logic                  speedConflict;
  logic                  powerConflict;

  assign sampleTick = (preCntReg >= PRE_LAST);

  always_ff @(posedge clkI) begin
    if (rstI)            preCntReg <= '0;
    else if (sampleTick) preCntReg <= '0;
    else                 preCntReg <= preCntReg + 1'b1;
  end

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : gDeb
    m3_key_debounce_bit #(
      .DEB_CNT       (DEB_CNT),
      .KEY_ACTIVE_LOW(KEY_ACTIVE_LOW)
    ) uDeb (
      .clkI      (clkI),
      .rstI      (rstI),
      .keyRawI   (keyRawI[gi]),
      .sampleTick(sampleTick),
      .stateO    (keyState[gi]),
      .pressO    (keyPress[gi])
    );
  end

  assign forceStop     = keyState[KEY_FORCE_STOP];
  assign speedConflict = keyState[KEY_SPD_DEC] & keyState[KEY_SPD_INC];
  assign powerConflict = keyState[KEY_PWR_INC] & keyState[KEY_PWR_DEC];

  // Lane gi serves key KEY_SPD_DEC+gi: speedDEC, speedINC, powerINC, powerDEC.
  for (genvar gi = 0; gi < NUM_REP; gi++) begin : gRep
    localparam int KI = KEY_SPD_DEC + gi;

    rep_state_t    stateReg, stateNext;
    logic [RW-1:0] repCntReg, repCntNext;
    logic          pulse;
    logic          forceIdle;

    assign forceIdle = forceStop | ((gi < 2) ? speedConflict : powerConflict);

    always_ff @(posedge clkI) begin
      if (rstI) begin
        stateReg  <= IDLE;
        repCntReg <= '0;
      end else begin
        stateReg  <= stateNext;
        repCntReg <= repCntNext;
      end
    end

    always_comb begin
      stateNext  = stateReg;
      repCntNext = repCntReg;
      pulse      = 1'b0;
      if (!keyState[KI] || forceIdle) begin
        stateNext  = IDLE;
        repCntNext = '0;
      end else begin
        case (stateReg)
          IDLE: begin
            if (keyPress[KI]) begin
              pulse      = 1'b1;
              stateNext  = HOLD;
              repCntNext = '0;
            end
          end
          HOLD: begin
            if (sampleTick) begin
              if (repCntReg >= DELAY_LAST) begin
                pulse      = 1'b1;
                stateNext  = REPEAT;
                repCntNext = '0;
              end else begin
                repCntNext = repCntReg + 1'b1;
              end
            end
          end
          REPEAT: begin
            if (sampleTick) begin
              if (repCntReg >= RATE_LAST) begin
                pulse      = 1'b1;
                repCntNext = '0;
              end else begin
                repCntNext = repCntReg + 1'b1;
              end
            end
          end
          default: begin
            stateNext  = IDLE;
            repCntNext = '0;
          end
        endcase
      end
    end

    assign repPulse[gi] = pulse;
  end

  always_ff @(posedge clkI) begin
    if (rstI) begin
      m3startO     <= 1'b0;
      m3forceStopO <= 1'b0;
      m3invRotateO <= 1'b0;
      cmdReg       <= '0;
    end else begin
      m3startO     <= keyPress[KEY_START] & ~forceStop;
      m3forceStopO <= forceStop;
      if (keyPress[KEY_INV_ROTATE]) m3invRotateO <= ~m3invRotateO;
      cmdReg       <= repPulse;
    end
  end

  assign m3speedDECo = cmdReg[0];
  assign m3speedINCo = cmdReg[1];
  assign m3powerINCo = cmdReg[2];
  assign m3powerDECo = cmdReg[3];
  assign keyStateO   = keyState;

endmodule
